load_dispatch: RTL and testbench

Parametrised, sequential successor to the load-queue instruction decoder. It accepts load-queue instructions over a valid/ready handshake and classifies each as input-load, weight-load or sync. It waits for a dependency token when the instruction's pop-next bit is set, issues one DMA request per load, waits for completion, and then emits a push-next token. It sits between the instruction fetch queue and the load DMA engines.

---
 rtl/load_dispatch.sv | 141 ++++++++++++++
 tb/tb_load_dispatch.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_dispatch.sv
// Sequential load-queue dispatcher: decodes one load instruction at a time, waits
// for a dependency token if requested, issues one DMA request and emits a push token.
module load_dispatch #(
    parameter int          INST_W    = 128,
    parameter int          XSIZE_LSB = 80,
    parameter int          XSIZE_W   = 16,
    parameter logic [2:0]  INPUT_ID  = 3'd2,
    parameter logic [2:0]  WEIGHT_ID = 3'd1,
    parameter int          TOKEN_W   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_inst_valid,
    output logic               io_inst_ready,
    input  logic [INST_W-1:0]  io_inst_bits,
    input  logic               io_pop_in,
    output logic               io_push_out,
    output logic               io_dma_valid,
    input  logic               io_dma_ready,
    output logic [1:0]         io_dma_sel,
    output logic [INST_W-1:0]  io_dma_inst,
    input  logic               io_dma_done,
    output logic               io_busy,
    output logic               io_err,
    output logic [TOKEN_W-1:0] io_tokens
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TOK,
        ISSUE,
        WAIT_DONE,
        FIN
    } state_t;

    localparam logic [TOKEN_W-1:0] TOKEN_ONE = TOKEN_W'(1);
    localparam logic [TOKEN_W-1:0] TOKEN_MAX = '1;

    state_t             state;
    state_t             nextState;
    logic [INST_W-1:0]  instReg;
    logic               errReg;
    logic [TOKEN_W-1:0] tokenCount;

    logic       isLoad;
    logic [2:0] memId;
    logic       popNext;
    logic       pushNext;
    logic       xsizeZero;
    logic       isInput;
    logic       isWeight;
    logic       isSync;
    logic       isLegal;
    logic       haveToken;
    logic       consume;
    logic       setErr;

    // Decode always looks at the latched word, so the fetch side may change freely.
    assign isLoad    = (instReg[2:0] == 3'd0);
    assign memId     = instReg[9:7];
    assign popNext   = instReg[4];
    assign pushNext  = instReg[6];
    assign xsizeZero = (instReg[XSIZE_LSB +: XSIZE_W] == '0);

    assign isInput   = isLoad && (memId == INPUT_ID)  && !xsizeZero;
    assign isWeight  = isLoad && (memId == WEIGHT_ID) && !xsizeZero;
    assign isSync    = isLoad && ((memId == INPUT_ID) || (memId == WEIGHT_ID)) && xsizeZero;
    assign isLegal   = isInput || isWeight || isSync;

    // Only a token already in the counter can be consumed; a pop arriving this
    // cycle is seen on the next evaluation.
    assign haveToken = (tokenCount != '0);
    assign consume   = (state == WAIT_TOK) && isLegal && popNext && haveToken;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        nextState = state;
        setErr    = 1'b0;
        unique case (state)
            IDLE: begin
                if (io_inst_valid) nextState = WAIT_TOK;
            end
            WAIT_TOK: begin
                if (!isLegal) begin
                    setErr    = 1'b1;
                    nextState = IDLE;
                end else if (!popNext || haveToken) begin
                    nextState = isSync ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                if (io_dma_ready) nextState = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (io_dma_done) nextState = FIN;
            end
            FIN: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            instReg <= '0;
            errReg  <= 1'b0;
        end else begin
            state <= nextState;
            if ((state == IDLE) && io_inst_valid) instReg <= io_inst_bits;
            if (setErr) errReg <= 1'b1;
        end
    end

    // Simultaneous pop and consume cancel; a pop at the maximum is dropped.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tokenCount <= '0;
        end else begin
            unique case ({io_pop_in, consume})
                2'b10:   if (tokenCount != TOKEN_MAX) tokenCount <= tokenCount + TOKEN_ONE;
                2'b01:   tokenCount <= tokenCount - TOKEN_ONE;
                default: tokenCount <= tokenCount;
            endcase
        end
    end

    assign io_inst_ready = (state == IDLE);
    assign io_busy       = (state != IDLE);
    assign io_dma_valid  = (state == ISSUE);
    assign io_dma_sel    = (state == ISSUE) ? {isWeight, isInput} : 2'b00;
    assign io_dma_inst   = instReg;
    assign io_push_out   = (state == FIN) && pushNext;
    assign io_err        = errReg;
    assign io_tokens     = tokenCount;

endmodule

// File: tb/tb_load_dispatch.sv
// Scoreboard bench for load_dispatch: expected DMA requests and push tokens are
// queued at instruction offer and compared when the DUT produces them.
module tb_load_dispatch;

    logic         clock;
    logic         reset;
    logic         io_inst_valid;
    logic         io_inst_ready;
    logic [127:0] io_inst_bits;
    logic         io_pop_in;
    logic         io_push_out;
    logic         io_dma_valid;
    logic         io_dma_ready;
    logic [1:0]   io_dma_sel;
    logic [127:0] io_dma_inst;
    logic         io_dma_done;
    logic         io_busy;
    logic         io_err;
    logic [3:0]   io_tokens;

    typedef struct {
        logic [1:0]   sel;
        logic [127:0] inst;
        logic         push;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nFails  = 0;
    int   expTokens = 0;

    load_dispatch dut (
        .clock         (clock),
        .reset         (reset),
        .io_inst_valid (io_inst_valid),
        .io_inst_ready (io_inst_ready),
        .io_inst_bits  (io_inst_bits),
        .io_pop_in     (io_pop_in),
        .io_push_out   (io_push_out),
        .io_dma_valid  (io_dma_valid),
        .io_dma_ready  (io_dma_ready),
        .io_dma_sel    (io_dma_sel),
        .io_dma_inst   (io_dma_inst),
        .io_dma_done   (io_dma_done),
        .io_busy       (io_busy),
        .io_err        (io_err),
        .io_tokens     (io_tokens)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, finished=0 required 1");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [127:0] makeInst(input logic [2:0] opcode, input logic pop,
                                              input logic push, input logic [2:0] memId,
                                              input logic [15:0] xsize);
        logic [127:0] w;
        w          = '0;
        w[2:0]     = opcode;
        w[4]       = pop;
        w[6]       = push;
        w[9:7]     = memId;
        w[95:80]   = xsize;
        w[127:96]  = 32'hA5C3_0F1E;
        return w;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic offerInst(input logic [127:0] inst, input logic legal,
                             input logic [1:0] sel, input logic push);
        exp_t e;
        int   n;
        n = 0;
        while (io_inst_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        nChecks++;
        if (io_inst_ready !== 1'b1) begin
            nFails++;
            $display("FAIL offer_ready: io_inst_ready=%b required 1", io_inst_ready);
        end
        io_inst_valid = 1'b1;
        io_inst_bits  = inst;
        tick();
        io_inst_valid = 1'b0;
        io_inst_bits  = '0;
        if (legal) begin
            e.sel  = sel;
            e.inst = inst;
            e.push = push;
            expQ.push_back(e);
        end
        nChecks++;
        if (io_busy !== 1'b1 || io_inst_ready !== 1'b0 || io_dma_valid !== 1'b0) begin
            nFails++;
            $display("FAIL accept_state: busy=%b ready=%b dma_valid=%b required 1 0 0",
                     io_busy, io_inst_ready, io_dma_valid);
        end
    endtask

    task automatic serviceDma(input int hold, output int waited);
        exp_t e;
        waited = 0;
        while (io_dma_valid !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        nChecks++;
        if (io_dma_valid !== 1'b1) begin
            nFails++;
            $display("FAIL dma_timeout: io_dma_valid=%b required 1", io_dma_valid);
            return;
        end
        nChecks++;
        if (expQ.size() == 0) begin
            nFails++;
            $display("FAIL dma_unexpected: queue size=0 required >0");
            return;
        end
        e = expQ[0];
        nChecks++;
        if (io_dma_sel !== e.sel) begin
            nFails++;
            $display("FAIL dma_sel: got %b required %b", io_dma_sel, e.sel);
        end
        nChecks++;
        if (io_dma_inst !== e.inst) begin
            nFails++;
            $display("FAIL dma_inst: got %h required %h", io_dma_inst, e.inst);
        end
        for (int i = 0; i < hold; i++) begin
            io_dma_ready = 1'b0;
            tick();
            nChecks++;
            if (io_dma_valid !== 1'b1 || io_dma_sel !== e.sel || io_dma_inst !== e.inst) begin
                nFails++;
                $display("FAIL dma_hold: valid=%b sel=%b inst=%h required 1 %b %h",
                         io_dma_valid, io_dma_sel, io_dma_inst, e.sel, e.inst);
            end
        end
        io_dma_ready = 1'b1;
        tick();
        io_dma_ready = 1'b0;
        nChecks++;
        if (io_dma_valid !== 1'b0 || io_busy !== 1'b1) begin
            nFails++;
            $display("FAIL dma_release: valid=%b busy=%b required 0 1", io_dma_valid, io_busy);
        end
    endtask

    task automatic finishDone(input int delay);
        exp_t e;
        for (int i = 0; i < delay; i++) begin
            tick();
            nChecks++;
            if (io_push_out !== 1'b0 || io_busy !== 1'b1) begin
                nFails++;
                $display("FAIL wait_done: push=%b busy=%b required 0 1", io_push_out, io_busy);
            end
        end
        io_dma_done = 1'b1;
        tick();
        io_dma_done = 1'b0;
        nChecks++;
        if (expQ.size() == 0) begin
            nFails++;
            $display("FAIL push_unexpected: queue size=0 required >0");
        end else begin
            e = expQ.pop_front();
            nChecks++;
            if (io_push_out !== e.push) begin
                nFails++;
                $display("FAIL push_pulse: got %b required %b", io_push_out, e.push);
            end
        end
        tick();
        nChecks++;
        if (io_push_out !== 1'b0 || io_inst_ready !== 1'b1) begin
            nFails++;
            $display("FAIL done_return: push=%b ready=%b required 0 1", io_push_out, io_inst_ready);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        nChecks++;
        if (io_inst_ready !== 1'b1 || io_busy !== 1'b0 || io_dma_valid !== 1'b0 ||
            io_dma_sel !== 2'b00 || io_push_out !== 1'b0 || io_err !== 1'b0 ||
            io_tokens !== 4'd0 || io_dma_inst !== 128'd0) begin
            nFails++;
            $display("FAIL %s: ready=%b busy=%b dv=%b sel=%b push=%b err=%b tok=%0d inst=%h required 1 0 0 00 0 0 0 0",
                     tag, io_inst_ready, io_busy, io_dma_valid, io_dma_sel, io_push_out,
                     io_err, io_tokens, io_dma_inst);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checkResetOutputs("reset_state");
        reset = 1'b1;
        tick();
    endtask

    task automatic test_sync();
        exp_t e;
        offerInst(128'h100, 1'b1, 2'b00, 1'b0);
        tick();
        nChecks++;
        if (io_dma_valid !== 1'b0 || io_busy !== 1'b1 || io_inst_ready !== 1'b0) begin
            nFails++;
            $display("FAIL sync_fin: dv=%b busy=%b ready=%b required 0 1 0",
                     io_dma_valid, io_busy, io_inst_ready);
        end
        e = expQ.pop_front();
        nChecks++;
        if (io_push_out !== e.push) begin
            nFails++;
            $display("FAIL sync_push: got %b required %b", io_push_out, e.push);
        end
        tick();
        nChecks++;
        if (io_inst_ready !== 1'b1 || io_push_out !== 1'b0 || io_dma_valid !== 1'b0) begin
            nFails++;
            $display("FAIL sync_ready: ready=%b push=%b dv=%b required 1 0 0",
                     io_inst_ready, io_push_out, io_dma_valid);
        end
    endtask

    task automatic test_input_load();
        int waited;
        offerInst(makeInst(3'd0, 1'b0, 1'b1, 3'd2, 16'd16), 1'b1, 2'b01, 1'b1);
        serviceDma(3, waited);
        nChecks++;
        if (waited !== 1) begin
            nFails++;
            $display("FAIL input_latency: waited %0d cycles required 1", waited);
        end
        finishDone(2);
    endtask

    task automatic test_weight_stall();
        int waited;
        nChecks++;
        if (io_tokens !== 4'd0) begin
            nFails++;
            $display("FAIL weight_pre_tokens: got %0d required 0", io_tokens);
        end
        offerInst(makeInst(3'd0, 1'b1, 1'b0, 3'd1, 16'd4), 1'b1, 2'b10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            nChecks++;
            if (io_dma_valid !== 1'b0 || io_busy !== 1'b1 || io_inst_ready !== 1'b0) begin
                nFails++;
                $display("FAIL weight_stall: dv=%b busy=%b ready=%b required 0 1 0",
                         io_dma_valid, io_busy, io_inst_ready);
            end
        end
        io_pop_in = 1'b1;
        tick();
        io_pop_in = 1'b0;
        nChecks++;
        if (io_tokens !== 4'd1 || io_dma_valid !== 1'b0) begin
            nFails++;
            $display("FAIL weight_token_in: tok=%0d dv=%b required 1 0", io_tokens, io_dma_valid);
        end
        tick();
        nChecks++;
        if (io_tokens !== 4'd0 || io_dma_valid !== 1'b1) begin
            nFails++;
            $display("FAIL weight_consume: tok=%0d dv=%b required 0 1", io_tokens, io_dma_valid);
        end
        serviceDma(0, waited);
        finishDone(1);
    endtask

    task automatic test_token_saturation();
        int waited;
        io_pop_in = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        io_pop_in = 1'b0;
        expTokens = 15;
        nChecks++;
        if (io_tokens !== 4'(expTokens)) begin
            nFails++;
            $display("FAIL token_saturate: got %0d required %0d", io_tokens, expTokens);
        end
        offerInst(makeInst(3'd0, 1'b1, 1'b1, 3'd1, 16'd8), 1'b1, 2'b10, 1'b1);
        io_pop_in = 1'b1;
        tick();
        io_pop_in = 1'b0;
        nChecks++;
        if (io_tokens !== 4'(expTokens) || io_dma_valid !== 1'b1) begin
            nFails++;
            $display("FAIL token_overlap: tok=%0d dv=%b required %0d 1", io_tokens, io_dma_valid, expTokens);
        end
        serviceDma(0, waited);
        finishDone(0);
        offerInst(makeInst(3'd0, 1'b1, 1'b0, 3'd2, 16'd1), 1'b1, 2'b01, 1'b0);
        tick();
        expTokens = 14;
        nChecks++;
        if (io_tokens !== 4'(expTokens) || io_dma_valid !== 1'b1) begin
            nFails++;
            $display("FAIL token_consume: tok=%0d dv=%b required %0d 1", io_tokens, io_dma_valid, expTokens);
        end
        serviceDma(1, waited);
        finishDone(0);
    endtask

    task automatic test_illegal();
        logic [127:0] bad[2];
        bad[0] = makeInst(3'd1, 1'b0, 1'b1, 3'd2, 16'd4);
        bad[1] = makeInst(3'd0, 1'b1, 1'b1, 3'd3, 16'd4);
        for (int k = 0; k < 2; k++) begin
            offerInst(bad[k], 1'b0, 2'b00, 1'b0);
            tick();
            nChecks++;
            if (io_err !== 1'b1 || io_dma_valid !== 1'b0 || io_push_out !== 1'b0 ||
                io_inst_ready !== 1'b1 || io_tokens !== 4'(expTokens)) begin
                nFails++;
                $display("FAIL illegal_%0d: err=%b dv=%b push=%b ready=%b tok=%0d required 1 0 0 1 %0d",
                         k, io_err, io_dma_valid, io_push_out, io_inst_ready, io_tokens, expTokens);
            end
        end
        tick();
        tick();
        nChecks++;
        if (io_err !== 1'b1 || io_dma_valid !== 1'b0) begin
            nFails++;
            $display("FAIL illegal_sticky: err=%b dv=%b required 1 0", io_err, io_dma_valid);
        end
    endtask

    task automatic test_reset_midflight();
        int waited;
        offerInst(makeInst(3'd0, 1'b0, 1'b1, 3'd2, 16'd32), 1'b1, 2'b01, 1'b1);
        serviceDma(0, waited);
        reset = 1'b0;
        tick();
        checkResetOutputs("reset_midflight");
        tick();
        reset = 1'b1;
        expQ.delete();
        expTokens = 0;
        io_dma_done = 1'b1;
        tick();
        io_dma_done = 1'b0;
        nChecks++;
        if (io_busy !== 1'b0 || io_push_out !== 1'b0 || io_inst_ready !== 1'b1) begin
            nFails++;
            $display("FAIL stale_done: busy=%b push=%b ready=%b required 0 0 1",
                     io_busy, io_push_out, io_inst_ready);
        end
        tick();
        nChecks++;
        if (io_push_out !== 1'b0 || io_busy !== 1'b0) begin
            nFails++;
            $display("FAIL stale_done_late: push=%b busy=%b required 0 0", io_push_out, io_busy);
        end
        offerInst(makeInst(3'd0, 1'b0, 1'b1, 3'd1, 16'd2), 1'b1, 2'b10, 1'b1);
        serviceDma(2, waited);
        finishDone(1);
        nChecks++;
        if (expQ.size() != 0 || io_err !== 1'b0) begin
            nFails++;
            $display("FAIL final_state: queue=%0d err=%b required 0 0", expQ.size(), io_err);
        end
    endtask

    initial begin
        reset         = 1'b0;
        io_inst_valid = 1'b0;
        io_inst_bits  = '0;
        io_pop_in     = 1'b0;
        io_dma_ready  = 1'b0;
        io_dma_done   = 1'b0;
        test_reset();
        test_sync();
        test_input_load();
        test_weight_stall();
        test_token_saturation();
        test_illegal();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
